memgame_display_core: RTL and testbench

// Output stage of the memorisation game. Compares the player's 16-bit entry with the target number.

---
 rtl/memgame_display_core.sv | 125 ++++++++++++
 tb/tb_memgame_display_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/memgame_display_core.sv
// Output stage of the memorisation game: refresh/blink tick generator, entry-vs-target
// equality checker, and a 4-digit multiplexed active-low 7-segment driver.
module memgame_display_core #(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_phase,
    input  logic [15:0] rand_int,
    input  logic [15:0] user_int,
    input  logic        input_ready,
    output logic        correct,
    output logic        fast_tick,
    output logic        blink,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    // Display source, listed in decreasing priority.
    localparam logic [1:0] SRC_TARGET = 2'd0;
    localparam logic [1:0] SRC_BLINK  = 2'd1;
    localparam logic [1:0] SRC_DASH   = 2'd2;
    localparam logic [1:0] SRC_ENTRY  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          fast_tick_q, fast_tick_d;
    logic          correct_q, correct_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    src;
    logic [15:0]   value;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        refresh_cnt_d = (refresh_cnt_q == REFRESH_LAST) ? '0 : refresh_cnt_q + RW'(1);
        fast_tick_d   = (refresh_cnt_q == REFRESH_LAST);
        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
        blink_d       = (blink_cnt_q == BLINK_LAST) ? ~blink_q : blink_q;
        correct_d     = (user_int == rand_int);
        idx_d         = fast_tick_q ? idx_q + 2'd1 : idx_q;

        if (display_phase)               src = SRC_TARGET;
        else if (input_ready && correct_q) src = SRC_BLINK;
        else if (input_ready)            src = SRC_DASH;
        else                             src = SRC_ENTRY;

        value = (src == SRC_TARGET) ? rand_int : user_int;
        case (idx_q)
            2'd0:    begin an_d = 4'b0111; nibble = value[15:12]; end
            2'd1:    begin an_d = 4'b1011; nibble = value[11:8];  end
            2'd2:    begin an_d = 4'b1101; nibble = value[7:4];   end
            default: begin an_d = 4'b1110; nibble = value[3:0];   end
        endcase

        case (src)
            SRC_BLINK: seg_d = blink_q ? hex_to_seg(nibble) : SEG_BLANK;
            SRC_DASH:  seg_d = SEG_DASH;
            default:   seg_d = hex_to_seg(nibble);
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            refresh_cnt_q <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b1;
            fast_tick_q   <= 1'b0;
            correct_q     <= 1'b0;
            idx_q         <= 2'd0;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
            fast_tick_q   <= fast_tick_d;
            correct_q     <= correct_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign correct   = correct_q;
    assign fast_tick = fast_tick_q;
    assign blink     = blink_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_memgame_display_core.sv
// Self-checking bench for memgame_display_core: directed mode steps plus random inputs,
// checked every cycle against an edge-count based model of the display behaviour.
module tb_memgame_display_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        display_phase;
    logic [15:0] rand_int;
    logic [15:0] user_int;
    logic        input_ready;
    logic        correct;
    logic        fast_tick;
    logic        blink;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;
    int n = 0;              // edges since reset released
    logic prev_corr = 1'b0; // expected correct after the previous edge
    logic [6:0] hex_tbl [16];

    memgame_display_core #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .rst(rst), .display_phase(display_phase), .rand_int(rand_int),
        .user_int(user_int), .input_ready(input_ready), .correct(correct),
        .fast_tick(fast_tick), .blink(blink), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Digit index and blink level after k edges of free running since reset.
    function automatic int idx_at(input int k);
        return (k < 1) ? 0 : ((k - 1) / 4) % 4;
    endfunction

    function automatic logic blink_at(input int k);
        return ((k / 16) % 2) == 0;
    endfunction

    task automatic step();
        int         i;
        logic [15:0] v;
        logic [3:0]  d;
        logic [6:0]  exp_seg;
        logic [3:0]  exp_an;
        @(posedge clk);
        #1;
        if (rst) begin
            n = 0;
            prev_corr = 1'b0;
            check("rst_an", 16'(an), 16'h000F);
            check("rst_seg", 16'(seg), 16'h007F);
            check("rst_blink", 16'(blink), 16'd1);
            check("rst_fast_tick", 16'(fast_tick), 16'd0);
            check("rst_correct", 16'(correct), 16'd0);
        end else begin
            n++;
            i = idx_at(n - 1);
            exp_an = 4'b1111 ^ (4'b1000 >> i);
            v = display_phase ? rand_int : user_int;
            d = 4'((v >> (4 * (3 - i))) & 16'hF);
            if (display_phase)               exp_seg = hex_tbl[d];
            else if (input_ready && prev_corr) exp_seg = blink_at(n - 1) ? hex_tbl[d] : 7'b1111111;
            else if (input_ready)            exp_seg = 7'b1111110;
            else                             exp_seg = hex_tbl[d];
            check("an", 16'(an), 16'(exp_an));
            check("seg", 16'(seg), 16'(exp_seg));
            check("fast_tick", 16'(fast_tick), 16'((n >= 4) && (n % 4 == 0)));
            check("blink", 16'(blink), 16'(blink_at(n)));
            check("correct", 16'(correct), 16'(user_int == rand_int));
            prev_corr = (user_int == rand_int);
        end
    endtask

    initial begin
        bit found;
        hex_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst = 1'b1;
        display_phase = 1'b0;
        input_ready = 1'b0;
        user_int = 16'h0000;
        rand_int = 16'hFFFF;

        // Reset for two cycles, then free-run scan showing the entry (all zeros).
        step();
        step();
        rst = 1'b0;
        repeat (24) step();

        // Target shown steady even with input_ready set.
        display_phase = 1'b1;
        rand_int = 16'h1A3F;
        input_ready = 1'b1;
        repeat (16) step();

        // Entry mode, mismatching values.
        display_phase = 1'b0;
        input_ready = 1'b0;
        user_int = 16'h0000;
        rand_int = 16'hFFFF;
        repeat (8) step();

        // Correct result blinks; run long enough to see both blink phases.
        input_ready = 1'b1;
        user_int = 16'hBEEF;
        rand_int = 16'hBEEF;
        repeat (40) step();

        // Wrong result shows dashes.
        user_int = 16'h1234;
        rand_int = 16'h1235;
        repeat (12) step();

        // Random mix of modes and values, changed every cycle.
        repeat (300) begin
            display_phase = ($urandom_range(0, 3) == 0);
            input_ready = $urandom_range(0, 1) != 0;
            user_int = 16'($urandom);
            rand_int = ($urandom_range(0, 1) != 0) ? user_int : 16'($urandom);
            step();
        end

        // Reset mid-scan at digit index 2 while blink is low.
        input_ready = 1'b1;
        user_int = 16'hC0DE;
        rand_int = 16'hC0DE;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (idx_at(n) == 2 && !blink_at(n)) found = 1'b1;
            else step();
        end
        check("found_idx2_blink0", 16'(found), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
